etherneco_packet_rx: RTL and testbench



---
 rtl/etherneco_pkg.sv | 22 ++
 rtl/etherneco_packet_rx_crc.sv | 43 ++++
 rtl/etherneco_packet_rx.sv | 224 ++++++++++++++++++++++
 tb/tb_etherneco_packet_rx.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/etherneco_pkg.sv
// Shared EtherNeco framing constants and the link-side state encoding.
package etherneco_pkg;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam int          PREAMBLE_LEN  = 8;
    localparam int          FCS_LEN       = 4;
    localparam logic [31:0] CRC_POLY      = 32'h04C11DB7;

    // one-hot, same encoding as the transmitter
    typedef enum logic [7:0] {
        ST_IDLE     = 8'b0000_0001,
        ST_PREAMBLE = 8'b0000_0010,
        ST_LENGTH   = 8'b0000_0100,
        ST_TYPE     = 8'b0000_1000,
        ST_NODE     = 8'b0001_0000,
        ST_PAYLOAD  = 8'b0010_0000,
        ST_FCS      = 8'b0100_0000,
        ST_DISCARD  = 8'b1000_0000
    } state_t;

endpackage

// File: rtl/etherneco_packet_rx_crc.sv
// Byte-serial CRC register (jelly2_calc_crc); in_update=0 restarts from the all-ones seed.
module jelly2_calc_crc #(
    parameter int                   DATA_WIDTH = 8,
    parameter int                   CRC_WIDTH  = 32,
    parameter logic [CRC_WIDTH-1:0] POLY_REPS  = 32'h04C11DB7,
    parameter bit                   REVERSED   = 1'b0
) (
    input  logic                  reset,
    input  logic                  clk,
    input  logic                  cke,
    input  logic                  in_update,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic [CRC_WIDTH-1:0]  out_crc
);

    function automatic logic [CRC_WIDTH-1:0] crc_step(input logic [CRC_WIDTH-1:0] crc,
                                                      input logic [DATA_WIDTH-1:0] data);
        logic [CRC_WIDTH-1:0] c;
        logic [CRC_WIDTH-1:0] poly_r;
        logic                 fb;
        c = crc;
        for (int i = 0; i < CRC_WIDTH; i++) poly_r[i] = POLY_REPS[CRC_WIDTH-1-i];
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (REVERSED) begin
                fb = c[0] ^ data[i];
                c  = (c >> 1) ^ (fb ? poly_r : '0);
            end else begin
                fb = c[CRC_WIDTH-1] ^ data[DATA_WIDTH-1-i];
                c  = (c << 1) ^ (fb ? POLY_REPS : '0);
            end
        end
        return c;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            out_crc <= '1;
        else if (cke && in_valid)
            out_crc <= crc_step(in_update ? out_crc : '1, in_data);
    end

endmodule

// File: rtl/etherneco_packet_rx.sv
// EtherNeco receiver: parses preamble/header/payload/FCS from an unstallable byte stream
// and reports one result per started packet.
module etherneco_packet_rx
    import etherneco_pkg::*;
#(
    parameter logic [15:0] MAX_LENGTH = 16'hffff
) (
    input  logic        rst,
    input  logic        clk,
    input  logic        s_rx_first,
    input  logic        s_rx_last,
    input  logic [7:0]  s_rx_data,
    input  logic        s_rx_valid,
    output logic [15:0] m_header_length,
    output logic [7:0]  m_header_type,
    output logic [7:0]  m_header_node,
    output logic        m_header_valid,
    output logic        m_payload_first,
    output logic        m_payload_last,
    output logic [7:0]  m_payload_data,
    output logic        m_payload_valid,
    output logic        m_result_ok,
    output logic        m_result_valid
);

    localparam logic [2:0] PRE_LAST = 3'(PREAMBLE_LEN - 1);
    localparam logic [2:0] FCS_LAST = 3'(FCS_LEN - 1);

    state_t      state, state_n;
    logic [2:0]  cnt, cnt_n;
    logic [15:0] len_acc, len_acc_n;
    logic [7:0]  type_acc, type_acc_n;
    logic [15:0] rem, rem_n;
    logic        pay_first, pay_first_n;
    logic [23:0] fcs_acc, fcs_acc_n;
    logic [31:0] crc_cap, crc_cap_n;
    logic [31:0] crc_val;
    logic        crc_valid, crc_update;
    logic        hdr_load, bad;
    logic        pay_valid_n, pay_first_o_n, pay_last_n;
    logic        res_valid_n, res_ok_n;
    logic        in_packet, fcs_end;

    // a result is still owed while a packet is being parsed
    assign in_packet = (state != ST_IDLE) && (state != ST_DISCARD);
    assign fcs_end   = (state == ST_FCS) && (cnt == FCS_LAST);

    jelly2_calc_crc #(
        .DATA_WIDTH (8),
        .CRC_WIDTH  (32),
        .POLY_REPS  (CRC_POLY),
        .REVERSED   (1'b0)
    ) u_crc (
        .reset      (~rst),
        .clk        (clk),
        .cke        (1'b1),
        .in_update  (crc_update),
        .in_data    (s_rx_data),
        .in_valid   (crc_valid),
        .out_crc    (crc_val)
    );

    always_comb begin
        state_n       = state;
        cnt_n         = cnt;
        len_acc_n     = len_acc;
        type_acc_n    = type_acc;
        rem_n         = rem;
        pay_first_n   = pay_first;
        fcs_acc_n     = fcs_acc;
        crc_cap_n     = crc_cap;
        crc_valid     = 1'b0;
        crc_update    = 1'b1;
        hdr_load      = 1'b0;
        bad           = 1'b0;
        pay_valid_n   = 1'b0;
        pay_first_o_n = 1'b0;
        pay_last_n    = 1'b0;
        res_valid_n   = 1'b0;
        res_ok_n      = 1'b0;

        if (s_rx_valid) begin
            if (s_rx_first) begin
                // close any open packet, then treat the byte as a fresh start
                res_valid_n = in_packet;
                state_n     = ST_IDLE;
                if (s_rx_data == PREAMBLE_BYTE) begin
                    if (s_rx_last) begin
                        res_valid_n = 1'b1;
                    end else begin
                        state_n = ST_PREAMBLE;
                        cnt_n   = 3'd1;
                    end
                end
            end else if (in_packet && s_rx_last && !fcs_end) begin
                res_valid_n = 1'b1;
                state_n     = ST_IDLE;
            end else begin
                case (state)
                    ST_PREAMBLE: begin
                        if (cnt == PRE_LAST) begin
                            if (s_rx_data == SFD_BYTE) begin
                                state_n = ST_LENGTH;
                                cnt_n   = 3'd0;
                            end else begin
                                bad = 1'b1;
                            end
                        end else if (s_rx_data == PREAMBLE_BYTE) begin
                            cnt_n = cnt + 3'd1;
                        end else begin
                            bad = 1'b1;
                        end
                    end
                    ST_LENGTH: begin
                        crc_valid  = 1'b1;
                        crc_update = (cnt != 3'd0);
                        if (cnt == 3'd0) begin
                            len_acc_n[7:0] = s_rx_data;
                            cnt_n          = 3'd1;
                        end else begin
                            len_acc_n[15:8] = s_rx_data;
                            if ({1'b0, s_rx_data, len_acc[7:0]} > {1'b0, MAX_LENGTH})
                                bad = 1'b1;
                            else
                                state_n = ST_TYPE;
                        end
                    end
                    ST_TYPE: begin
                        crc_valid  = 1'b1;
                        type_acc_n = s_rx_data;
                        state_n    = ST_NODE;
                    end
                    ST_NODE: begin
                        crc_valid   = 1'b1;
                        hdr_load    = 1'b1;
                        rem_n       = len_acc;
                        pay_first_n = 1'b1;
                        state_n     = ST_PAYLOAD;
                    end
                    ST_PAYLOAD: begin
                        crc_valid     = 1'b1;
                        pay_valid_n   = 1'b1;
                        pay_first_o_n = pay_first;
                        pay_last_n    = (rem == 16'd0);
                        pay_first_n   = 1'b0;
                        if (rem == 16'd0) begin
                            state_n = ST_FCS;
                            cnt_n   = 3'd0;
                        end else begin
                            rem_n = rem - 16'd1;
                        end
                    end
                    ST_FCS: begin
                        // CRC register already covers the last payload byte here
                        if (cnt == 3'd0) crc_cap_n = crc_val;
                        if (fcs_end) begin
                            res_valid_n = 1'b1;
                            res_ok_n    = s_rx_last && ({s_rx_data, fcs_acc} == crc_cap);
                            state_n     = s_rx_last ? ST_IDLE : ST_DISCARD;
                        end else begin
                            fcs_acc_n = {s_rx_data, fcs_acc[23:8]};
                            cnt_n     = cnt + 3'd1;
                        end
                    end
                    ST_DISCARD: begin
                        if (s_rx_last) state_n = ST_IDLE;
                    end
                    default: begin
                    end
                endcase
                if (bad) begin
                    res_valid_n = 1'b1;
                    state_n     = ST_DISCARD;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= ST_IDLE;
            cnt             <= 3'd0;
            len_acc         <= 16'd0;
            type_acc        <= 8'd0;
            rem             <= 16'd0;
            pay_first       <= 1'b0;
            fcs_acc         <= 24'd0;
            crc_cap         <= 32'd0;
            m_header_length <= 16'd0;
            m_header_type   <= 8'd0;
            m_header_node   <= 8'd0;
            m_header_valid  <= 1'b0;
            m_payload_first <= 1'b0;
            m_payload_last  <= 1'b0;
            m_payload_data  <= 8'd0;
            m_payload_valid <= 1'b0;
            m_result_ok     <= 1'b0;
            m_result_valid  <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            len_acc   <= len_acc_n;
            type_acc  <= type_acc_n;
            rem       <= rem_n;
            pay_first <= pay_first_n;
            fcs_acc   <= fcs_acc_n;
            crc_cap   <= crc_cap_n;

            m_header_valid <= hdr_load;
            if (hdr_load) begin
                m_header_length <= len_acc;
                m_header_type   <= type_acc;
                m_header_node   <= s_rx_data;
            end
            m_payload_valid <= pay_valid_n;
            m_payload_first <= pay_first_o_n;
            m_payload_last  <= pay_last_n;
            if (pay_valid_n) m_payload_data <= s_rx_data;
            m_result_valid  <= res_valid_n;
            m_result_ok     <= res_ok_n;
        end
    end

endmodule

// File: tb/tb_etherneco_packet_rx.sv
// Self-checking bench for etherneco_packet_rx: packets built from the framing rules,
// outputs collected by a monitor and compared per scenario.
module tb_etherneco_packet_rx;

    typedef logic [7:0] byte_q_t [$];

    logic        rst, clk;
    logic        s_rx_first, s_rx_last, s_rx_valid;
    logic [7:0]  s_rx_data;
    logic [15:0] m_header_length;
    logic [7:0]  m_header_type, m_header_node, m_payload_data;
    logic        m_header_valid, m_payload_first, m_payload_last, m_payload_valid;
    logic        m_result_ok, m_result_valid;

    int n_chk = 0, n_fail = 0, cyc = 0;
    logic [31:0] hdr_q [$];
    logic [9:0]  pay_q [$];
    logic        res_q [$];
    int          res_cyc_q [$];

    etherneco_packet_rx dut (
        .rst(rst), .clk(clk),
        .s_rx_first(s_rx_first), .s_rx_last(s_rx_last), .s_rx_data(s_rx_data), .s_rx_valid(s_rx_valid),
        .m_header_length(m_header_length), .m_header_type(m_header_type), .m_header_node(m_header_node),
        .m_header_valid(m_header_valid), .m_payload_first(m_payload_first), .m_payload_last(m_payload_last),
        .m_payload_data(m_payload_data), .m_payload_valid(m_payload_valid),
        .m_result_ok(m_result_ok), .m_result_valid(m_result_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (m_header_valid)  hdr_q.push_back({m_header_length, m_header_type, m_header_node});
        if (m_payload_valid) pay_q.push_back({m_payload_first, m_payload_last, m_payload_data});
        if (m_result_valid) begin
            res_q.push_back(m_result_ok);
            res_cyc_q.push_back(cyc);
        end
    end

    // CRC-32/MPEG-2 style: MSB first, all-ones seed, no final xor
    function automatic logic [31:0] crc32(input byte_q_t q);
        logic [31:0] c = 32'hffff_ffff;
        foreach (q[k]) begin
            c ^= {q[k], 24'h0};
            for (int b = 0; b < 8; b++) c = c[31] ? ((c << 1) ^ 32'h04C1_1DB7) : (c << 1);
        end
        return c;
    endfunction

    function automatic byte_q_t build_pkt(input logic [7:0] typ, input logic [7:0] node, input byte_q_t pay);
        byte_q_t body, pkt;
        logic [15:0] len;
        logic [31:0] fcs;
        len = 16'(pay.size() - 1);
        body.push_back(len[7:0]);
        body.push_back(len[15:8]);
        body.push_back(typ);
        body.push_back(node);
        foreach (pay[i]) body.push_back(pay[i]);
        fcs = crc32(body);
        for (int i = 0; i < 7; i++) pkt.push_back(8'h55);
        pkt.push_back(8'hD5);
        foreach (body[i]) pkt.push_back(body[i]);
        for (int i = 0; i < 4; i++) pkt.push_back(fcs[8*i +: 8]);
        return pkt;
    endfunction

    task automatic put(input bit f, input bit l, input logic [7:0] d);
        @(posedge clk); #1;
        s_rx_valid = 1'b1; s_rx_first = f; s_rx_last = l; s_rx_data = d;
    endtask

    task automatic idle1();
        @(posedge clk); #1;
        s_rx_valid = 1'b0; s_rx_first = 1'b0; s_rx_last = 1'b0; s_rx_data = 8'($urandom);
    endtask

    task automatic flush(input int n);
        repeat (n) idle1();
    endtask

    task automatic send(input byte_q_t pkt, input int n, input bit mark_last, input int gmin, input int gmax);
        for (int i = 0; i < n; i++) begin
            put(i == 0, mark_last && (i == n - 1), pkt[i]);
            repeat ($urandom_range(gmax, gmin)) idle1();
        end
    endtask

    task automatic clear();
        hdr_q.delete(); pay_q.delete(); res_q.delete(); res_cyc_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b0; s_rx_valid = 1'b0; s_rx_first = 1'b0; s_rx_last = 1'b0; s_rx_data = 8'h00;
        repeat (3) @(negedge clk);
        n_chk++;
        if ({m_header_length, m_header_type, m_header_node, m_header_valid, m_payload_first, m_payload_last,
             m_payload_data, m_payload_valid, m_result_ok, m_result_valid} !== 46'd0) begin
            n_fail++; $display("FAIL reset_outputs: outputs not all zero in reset");
        end
        rst = 1'b1;
        flush(2);
    endtask

    task automatic test_loopback();
        byte_q_t pay = '{8'h11, 8'h22, 8'h33, 8'h44};
        byte_q_t pkt;
        logic [9:0] e;
        clear();
        pkt = build_pkt(8'h10, 8'h02, pay);
        send(pkt, pkt.size(), 1'b1, 0, 0);
        flush(4);
        n_chk++;
        if (hdr_q.size() != 1 || hdr_q[0] !== {16'd3, 8'h10, 8'h02}) begin
            n_fail++; $display("FAIL loopback_hdr: %0d headers, want 1 of 0003_10_02", hdr_q.size());
        end
        n_chk++;
        if (pay_q.size() != 4) begin n_fail++; $display("FAIL loopback_pay_cnt: got %0d want 4", pay_q.size()); end
        for (int i = 0; i < 4 && i < pay_q.size(); i++) begin
            e = {i == 0, i == 3, pay[i]};
            n_chk++;
            if (pay_q[i] !== e) begin n_fail++; $display("FAIL loopback_pay[%0d]: got %h want %h", i, pay_q[i], e); end
        end
        n_chk++;
        if (res_q.size() != 1 || res_q[0] !== 1'b1) begin
            n_fail++; $display("FAIL loopback_result: %0d results, want one ok=1", res_q.size());
        end
    endtask

    task automatic test_fcs_error();
        byte_q_t pay = '{8'h11, 8'h22, 8'h33, 8'h44};
        byte_q_t pkt;
        clear();
        pkt = build_pkt(8'h10, 8'h02, pay);
        pkt[pkt.size() - 3] ^= 8'h08;
        send(pkt, pkt.size(), 1'b1, 0, 0);
        flush(4);
        n_chk++;
        if (pay_q.size() != 4) begin n_fail++; $display("FAIL fcserr_pay_cnt: got %0d want 4", pay_q.size()); end
        n_chk++;
        if (res_q.size() != 1 || res_q[0] !== 1'b0) begin
            n_fail++; $display("FAIL fcserr_result: %0d results, want one ok=0", res_q.size());
        end
    endtask

    task automatic test_abort();
        byte_q_t pay = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
        byte_q_t pkt;
        int c;
        clear();
        pkt = build_pkt(8'h33, 8'h07, pay);
        send(pkt, 14, 1'b0, 0, 0);
        put(1'b0, 1'b1, 8'h00);
        c = cyc;
        flush(4);
        n_chk++;
        if (pay_q.size() != 2 || pay_q[0] !== {2'b10, 8'hA1} || pay_q[1] !== {2'b00, 8'hA2}) begin
            n_fail++; $display("FAIL abort_pay: got %0d bytes, want A1(first) A2 without last", pay_q.size());
        end
        n_chk++;
        if (res_q.size() != 1 || res_q[0] !== 1'b0) begin
            n_fail++; $display("FAIL abort_result: %0d results, want one ok=0", res_q.size());
        end
        n_chk++;
        if (res_cyc_q.size() != 1 || res_cyc_q[0] != c + 1) begin
            n_fail++; $display("FAIL abort_timing: result at cycle %0d want %0d",
                               res_cyc_q.size() ? res_cyc_q[0] : -1, c + 1);
        end
        clear();
        send(pkt, pkt.size(), 1'b1, 0, 0);
        flush(4);
        n_chk++;
        if (res_q.size() != 1 || res_q[0] !== 1'b1) begin
            n_fail++; $display("FAIL abort_next_ok: %0d results, want one ok=1", res_q.size());
        end
    endtask

    task automatic test_bad_preamble();
        byte_q_t pay = '{8'h5A, 8'h6B};
        byte_q_t pkt, good;
        clear();
        good = build_pkt(8'h44, 8'h09, pay);
        pkt = good;
        pkt[4] = 8'h54;
        send(pkt, pkt.size(), 1'b1, 0, 0);
        flush(3);
        n_chk++;
        if (hdr_q.size() != 0 || pay_q.size() != 0) begin
            n_fail++; $display("FAIL badpre_output: %0d headers %0d payload, want none", hdr_q.size(), pay_q.size());
        end
        n_chk++;
        if (res_q.size() != 1 || res_q[0] !== 1'b0) begin
            n_fail++; $display("FAIL badpre_result: %0d results, want one ok=0", res_q.size());
        end
        clear();
        send(good, good.size(), 1'b1, 0, 0);
        flush(3);
        n_chk++;
        if (hdr_q.size() != 1 || hdr_q[0] !== {16'd1, 8'h44, 8'h09} || res_q.size() != 1 || res_q[0] !== 1'b1) begin
            n_fail++; $display("FAIL badpre_next: %0d headers %0d results, want normal packet ok=1",
                               hdr_q.size(), res_q.size());
        end
    endtask

    task automatic test_len0_gaps();
        byte_q_t pay = '{8'hC3};
        byte_q_t pkt;
        clear();
        pkt = build_pkt(8'h01, 8'hFE, pay);
        send(pkt, pkt.size(), 1'b1, 1, 1);
        flush(3);
        n_chk++;
        if (hdr_q.size() != 1 || hdr_q[0] !== {16'd0, 8'h01, 8'hFE}) begin
            n_fail++; $display("FAIL len0_hdr: %0d headers, want one 0000_01_FE", hdr_q.size());
        end
        n_chk++;
        if (pay_q.size() != 1 || pay_q[0] !== {2'b11, 8'hC3}) begin
            n_fail++; $display("FAIL len0_pay: %0d bytes, want one C3 with first=last=1", pay_q.size());
        end
        n_chk++;
        if (res_q.size() != 1 || res_q[0] !== 1'b1) begin
            n_fail++; $display("FAIL len0_result: %0d results, want one ok=1", res_q.size());
        end
    endtask

    task automatic test_first_mid_payload();
        byte_q_t p_old = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        byte_q_t p_new = '{8'hE0, 8'hE1, 8'hE2};
        byte_q_t a, b;
        clear();
        a = build_pkt(8'h21, 8'h03, p_old);
        b = build_pkt(8'h22, 8'h04, p_new);
        send(a, 15, 1'b0, 0, 0);
        send(b, b.size(), 1'b1, 0, 0);
        flush(3);
        n_chk++;
        if (res_q.size() != 2 || res_q[0] !== 1'b0 || res_q[1] !== 1'b1) begin
            n_fail++; $display("FAIL midfirst_results: %0d results, want ok=0 then ok=1", res_q.size());
        end
        n_chk++;
        if (hdr_q.size() != 2 || pay_q.size() != 6) begin
            n_fail++; $display("FAIL midfirst_counts: %0d headers %0d payload, want 2 and 6", hdr_q.size(), pay_q.size());
        end
        n_chk++;
        if (pay_q.size() == 6 && pay_q[5] !== {2'b01, 8'hE2}) begin
            n_fail++; $display("FAIL midfirst_last: got %h want %h", pay_q[5], {2'b01, 8'hE2});
        end
        clear();
        put(1'b1, 1'b1, 8'h55);
        flush(3);
        n_chk++;
        if (res_q.size() != 1 || res_q[0] !== 1'b0 || hdr_q.size() != 0) begin
            n_fail++; $display("FAIL first_last: %0d results %0d headers, want one ok=0, no header",
                               res_q.size(), hdr_q.size());
        end
    endtask

    task automatic test_random();
        byte_q_t pay, pkt;
        logic [7:0] typ, node;
        logic [9:0] e;
        bit corrupt;
        int n, k;
        for (int p = 0; p < 16; p++) begin
            clear();
            pay.delete();
            n = $urandom_range(24, 1);
            repeat (n) pay.push_back(8'($urandom));
            typ = 8'($urandom); node = 8'($urandom);
            pkt = build_pkt(typ, node, pay);
            corrupt = ($urandom_range(3, 0) == 0);
            if (corrupt) begin
                k = pkt.size() - 1 - $urandom_range(3, 0);
                pkt[k] ^= 8'(1 << $urandom_range(7, 0));
            end
            send(pkt, pkt.size(), 1'b1, 0, 2);
            flush(3);
            n_chk++;
            if (hdr_q.size() != 1 || hdr_q[0] !== {16'(n - 1), typ, node}) begin
                n_fail++; $display("FAIL rand%0d_hdr: %0d headers", p, hdr_q.size());
            end
            n_chk++;
            if (pay_q.size() != n) begin n_fail++; $display("FAIL rand%0d_pay_cnt: got %0d want %0d", p, pay_q.size(), n); end
            for (int i = 0; i < n && i < pay_q.size(); i++) begin
                e = {i == 0, i == n - 1, pay[i]};
                n_chk++;
                if (pay_q[i] !== e) begin n_fail++; $display("FAIL rand%0d_pay[%0d]: got %h want %h", p, i, pay_q[i], e); end
            end
            n_chk++;
            if (res_q.size() != 1 || res_q[0] !== !corrupt) begin
                n_fail++; $display("FAIL rand%0d_result: %0d results, want one ok=%0d", p, res_q.size(), !corrupt);
            end
        end
    endtask

    task automatic test_reset_mid();
        byte_q_t pay = '{8'h99, 8'h88, 8'h77, 8'h66};
        byte_q_t pkt;
        clear();
        pkt = build_pkt(8'h5C, 8'h3D, pay);
        send(pkt, 14, 1'b0, 0, 0);
        @(posedge clk); #2;
        n_chk++;
        if (m_payload_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre: payload_valid got %b want 1", m_payload_valid); end
        rst = 1'b0;
        #1;
        n_chk++;
        if ({m_header_length, m_header_type, m_header_node, m_header_valid, m_payload_first, m_payload_last,
             m_payload_data, m_payload_valid, m_result_ok, m_result_valid} !== 46'd0) begin
            n_fail++; $display("FAIL rstmid_async: outputs not cleared immediately by reset");
        end
        s_rx_valid = 1'b0; s_rx_first = 1'b0; s_rx_last = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        flush(4);
        n_chk++;
        if (res_q.size() != 0) begin n_fail++; $display("FAIL rstmid_noresult: got %0d results want 0", res_q.size()); end
        send(pkt, pkt.size(), 1'b1, 0, 1);
        flush(3);
        n_chk++;
        if (res_q.size() != 1 || res_q[0] !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_next: %0d results, want one ok=1", res_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_fcs_error();
        test_abort();
        test_bad_preamble();
        test_len0_gaps();
        test_first_mid_payload();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
